// File: rtl/wshb_pkg.sv
// Shared types and sizing helpers for the Wishbone classic-cycle slave memory.
package wshb_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    // Cycle termination chosen for an accepted request; err > rty > ack.
    typedef enum logic [1:0] {TERM_ACK, TERM_ERR, TERM_RTY} term_t;

    function automatic int sel_width(input int dwidth);
        return dwidth / BYTE_W;
    endfunction

    function automatic int off_width(input int dwidth);
        return $clog2(dwidth / BYTE_W);
    endfunction

endpackage

// File: rtl/wshb_s_mem_if.sv
// Wishbone classic-cycle bus bundle; signal suffixes are from the slave's view.
interface wshb_s_mem_if #(
    parameter int DWIDTH = 64,
    parameter int AWIDTH = 32
);
    logic [DWIDTH-1:0]   wb_dat_i;
    logic [DWIDTH-1:0]   wb_dat_o;
    logic [AWIDTH-1:0]   wb_adr_i;
    logic                wb_cyc_i;
    logic                wb_stb_i;
    logic                wb_we_i;
    logic [DWIDTH/8-1:0] wb_sel_i;
    logic                wb_ack_o;
    logic                wb_err_o;
    logic                wb_rty_o;

    modport slave (
        input  wb_dat_i, wb_adr_i, wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i,
        output wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
    );

    modport master (
        output wb_dat_i, wb_adr_i, wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i,
        input  wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
    );
endinterface

// File: rtl/wshb_s_ram.sv
// Single-port word RAM with per-byte write enables and a registered read port.
module wshb_s_ram
    import wshb_pkg::*;
#(
    parameter int DWIDTH = 64,
    parameter int DEPTH  = 256
) (
    input  logic                         clk,
    input  logic [$clog2(DEPTH)-1:0]     addr,
    input  logic                         we,
    input  logic [sel_width(DWIDTH)-1:0] be,
    input  logic [DWIDTH-1:0]            wdata,
    output logic [DWIDTH-1:0]            rdata
);

    logic [DWIDTH-1:0] mem [DEPTH];

    // NOTE: no reset on the array so it maps onto block RAM; contents survive rst.
    always_ff @(posedge clk) begin
        for (int b = 0; b < sel_width(DWIDTH); b++) begin
            if (we && be[b]) begin
                mem[addr][b*BYTE_W +: BYTE_W] <= wdata[b*BYTE_W +: BYTE_W];
            end
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/wshb_s_mem.sv
// Wishbone classic-cycle slave over a byte-enable word RAM, with programmable
// wait states, out-of-range error and a retry-injection hook.
module wshb_s_mem
    import wshb_pkg::*;
#(
    parameter int DWIDTH   = 64,
    parameter int AWIDTH   = 32,
    parameter int DEPTH    = 256,
    parameter int WAIT_CYC = 0
) (
    input  logic        clk,
    input  logic        rst,
    wshb_s_mem_if.slave wb,
    input  logic        rty_req_i,
    output logic [15:0] xfer_cnt_o
);

    localparam int SEL_W = sel_width(DWIDTH);
    localparam int OFF_W = off_width(DWIDTH);
    localparam int IDX_W = $clog2(DEPTH);

    state_t            state;
    logic [3:0]        wait_cnt;
    logic [AWIDTH-1:0] adr_q;
    logic              we_q;
    logic [SEL_W-1:0]  sel_q;
    logic [DWIDTH-1:0] dat_q;
    logic              rty_q;
    logic              ack_q, err_q, rty_o_q;
    logic              rd_q;
    logic [DWIDTH-1:0] dat_hold;
    logic [DWIDTH-1:0] ram_rdata;

    logic              req, in_idle, out_of_range, go_resp, ram_we;
    logic [AWIDTH-1:0] cur_adr;
    logic              cur_we, cur_rty;
    logic [SEL_W-1:0]  cur_sel;
    logic [DWIDTH-1:0] cur_dat;
    term_t             term;

    // In IDLE the live bus is the request (zero-wait path); later it is the latched copy.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        req          = wb.wb_cyc_i & wb.wb_stb_i;
        in_idle      = (state == IDLE);
        cur_adr      = in_idle ? wb.wb_adr_i : adr_q;
        cur_we       = in_idle ? wb.wb_we_i  : we_q;
        cur_sel      = in_idle ? wb.wb_sel_i : sel_q;
        cur_dat      = in_idle ? wb.wb_dat_i : dat_q;
        cur_rty      = in_idle ? rty_req_i   : rty_q;
        out_of_range = |(cur_adr >> (OFF_W + IDX_W));
        term         = TERM_ACK;
        if (out_of_range) begin
            term = TERM_ERR;
        end else if (cur_rty) begin
            term = TERM_RTY;
        end
        go_resp = req & ((in_idle & (WAIT_CYC == 0)) |
                         ((state == WAIT) & (wait_cnt == 4'd1)));
        ram_we  = go_resp & cur_we & (term == TERM_ACK);
    end

    wshb_s_ram #(
        .DWIDTH (DWIDTH),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk   (clk),
        .addr  (cur_adr[OFF_W +: IDX_W]),
        .we    (ram_we),
        .be    (cur_sel),
        .wdata (cur_dat),
        .rdata (ram_rdata)
    );

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            adr_q      <= '0;
            we_q       <= 1'b0;
            sel_q      <= '0;
            dat_q      <= '0;
            rty_q      <= 1'b0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            rty_o_q    <= 1'b0;
            rd_q       <= 1'b0;
            dat_hold   <= '0;
            xfer_cnt_o <= '0;
        end else begin
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rty_o_q <= 1'b0;
            rd_q    <= 1'b0;

            case (state)
                IDLE: if (req) begin
                    adr_q <= wb.wb_adr_i;
                    we_q  <= wb.wb_we_i;
                    sel_q <= wb.wb_sel_i;
                    dat_q <= wb.wb_dat_i;
                    rty_q <= rty_req_i;
                    if (WAIT_CYC == 0) begin
                        state <= RESP;
                    end else begin
                        wait_cnt <= 4'(WAIT_CYC);
                        state    <= WAIT;
                    end
                end
                WAIT: if (!req) begin
                    wait_cnt <= '0;
                    state    <= IDLE;
                end else begin
                    wait_cnt <= wait_cnt - 4'd1;
                    if (wait_cnt == 4'd1) state <= RESP;
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase

            if (go_resp) begin
                case (term)
                    TERM_ERR: begin
                        err_q <= 1'b1;
                        if (!cur_we) dat_hold <= '0;
                    end
                    TERM_RTY: begin
                        rty_o_q <= 1'b1;
                        if (!cur_we) dat_hold <= '0;
                    end
                    default: begin
                        ack_q      <= 1'b1;
                        xfer_cnt_o <= xfer_cnt_o + 16'd1;
                        rd_q       <= ~cur_we;
                    end
                endcase
            end

            // Capture the read word as the ack cycle ends so dat_o holds it afterwards.
            if (rd_q) dat_hold <= ram_rdata;
        end
    end

    assign wb.wb_ack_o = ack_q;
    assign wb.wb_err_o = err_q;
    assign wb.wb_rty_o = rty_o_q;
    assign wb.wb_dat_o = rd_q ? ram_rdata : dat_hold;

endmodule

// File: tb/tb_wshb_s_mem.sv
// Self-checking bench: zero-wait slave driven from a vector table and random
// traffic against a word-array model; three-wait slave for abort/retry/reset.
module tb_wshb_s_mem;

    localparam logic [2:0] T_NONE = 3'b000;
    localparam logic [2:0] T_ACK  = 3'b100;
    localparam logic [2:0] T_ERR  = 3'b010;
    localparam logic [2:0] T_RTY  = 3'b001;

    logic        clk = 1'b0;
    logic        rst0, rst3;
    logic        rty_req0, rty_req3;
    logic [15:0] cnt0, cnt3;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    wshb_s_mem_if #(.DWIDTH(64), .AWIDTH(32)) if0 ();
    wshb_s_mem_if #(.DWIDTH(64), .AWIDTH(32)) if3 ();

    wshb_s_mem #(.DWIDTH(64), .AWIDTH(32), .DEPTH(256), .WAIT_CYC(0)) dut0 (
        .clk(clk), .rst(rst0), .wb(if0.slave), .rty_req_i(rty_req0), .xfer_cnt_o(cnt0)
    );
    wshb_s_mem #(.DWIDTH(64), .AWIDTH(32), .DEPTH(256), .WAIT_CYC(3)) dut3 (
        .clk(clk), .rst(rst3), .wb(if3.slave), .rty_req_i(rty_req3), .xfer_cnt_o(cnt3)
    );

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [7:0]  sel;
        logic [63:0] dat;
        logic        rty;
        logic [2:0]  exp_t;
        logic [63:0] exp_dat;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t        vecs [19];
    logic [63:0] mdl [16];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One transfer on the zero-wait slave; lat = negedges until a termination (0 = none in budget).
    task automatic xfer0(input logic we, input logic [31:0] adr, input logic [7:0] sel,
                         input logic [63:0] dat, input logic rty,
                         output logic [2:0] term, output logic [63:0] rd,
                         output logic [15:0] cnt, output int lat);
        @(negedge clk);
        if0.wb_cyc_i = 1'b1; if0.wb_stb_i = 1'b1; if0.wb_we_i = we;
        if0.wb_adr_i = adr;  if0.wb_sel_i = sel;  if0.wb_dat_i = dat; rty_req0 = rty;
        term = T_NONE; rd = '0; cnt = '0; lat = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (if0.wb_ack_o | if0.wb_err_o | if0.wb_rty_o) begin
                term = {if0.wb_ack_o, if0.wb_err_o, if0.wb_rty_o};
                rd = if0.wb_dat_o; cnt = cnt0; lat = i;
                break;
            end
        end
        if0.wb_cyc_i = 1'b0; if0.wb_stb_i = 1'b0; rty_req0 = 1'b0;
    endtask

    // Same for the three-wait slave, with optional strobe drop / late retry request at a negedge.
    task automatic xfer3(input logic we, input logic [31:0] adr, input logic [63:0] dat,
                         input int drop_at, input int rty_at,
                         output logic [2:0] term, output logic [63:0] rd,
                         output logic [15:0] cnt, output int lat);
        @(negedge clk);
        if3.wb_cyc_i = 1'b1; if3.wb_stb_i = 1'b1; if3.wb_we_i = we;
        if3.wb_adr_i = adr;  if3.wb_sel_i = 8'hFF; if3.wb_dat_i = dat; rty_req3 = 1'b0;
        term = T_NONE; rd = '0; cnt = '0; lat = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (lat == 0 && (if3.wb_ack_o | if3.wb_err_o | if3.wb_rty_o)) begin
                term = {if3.wb_ack_o, if3.wb_err_o, if3.wb_rty_o};
                rd = if3.wb_dat_o; cnt = cnt3; lat = i;
                break;
            end
            if (i == drop_at) if3.wb_stb_i = 1'b0;
            if (i == rty_at)  rty_req3 = 1'b1;
        end
        if3.wb_cyc_i = 1'b0; if3.wb_stb_i = 1'b0; rty_req3 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [2:0]  term, exp_t;
        logic [63:0] rd, dat, exp_dat;
        logic [15:0] cnt, exp_cnt;
        logic [31:0] adr;
        logic [7:0]  sel;
        logic        we, rty, oor;
        int          lat, idx;

        vecs[0]  = '{1'b1, 32'h10,        8'hFF, 64'h1122334455667788, 1'b0, T_ACK, 64'h0,                16'd1};
        vecs[1]  = '{1'b0, 32'h10,        8'hFF, 64'h0,                1'b0, T_ACK, 64'h1122334455667788, 16'd2};
        vecs[2]  = '{1'b1, 32'h10,        8'h0F, 64'hFFFFFFFFFFFFFFFF, 1'b0, T_ACK, 64'h1122334455667788, 16'd3};
        vecs[3]  = '{1'b0, 32'h10,        8'hFF, 64'h0,                1'b0, T_ACK, 64'h11223344FFFFFFFF, 16'd4};
        vecs[4]  = '{1'b1, 32'h00,        8'hFF, 64'hDEADBEEFCAFEF00D, 1'b0, T_ACK, 64'h11223344FFFFFFFF, 16'd5};
        vecs[5]  = '{1'b1, 32'h800,       8'hFF, 64'h5555555555555555, 1'b0, T_ERR, 64'h11223344FFFFFFFF, 16'd5};
        vecs[6]  = '{1'b0, 32'h00,        8'hFF, 64'h0,                1'b0, T_ACK, 64'hDEADBEEFCAFEF00D, 16'd6};
        vecs[7]  = '{1'b1, 32'h18,        8'hFF, 64'h0123456789ABCDEF, 1'b0, T_ACK, 64'hDEADBEEFCAFEF00D, 16'd7};
        vecs[8]  = '{1'b1, 32'h18,        8'hFF, 64'h00000000000000AA, 1'b1, T_RTY, 64'hDEADBEEFCAFEF00D, 16'd7};
        vecs[9]  = '{1'b0, 32'h18,        8'hFF, 64'h0,                1'b0, T_ACK, 64'h0123456789ABCDEF, 16'd8};
        vecs[10] = '{1'b1, 32'h18,        8'hFF, 64'h00000000000000AA, 1'b0, T_ACK, 64'h0123456789ABCDEF, 16'd9};
        vecs[11] = '{1'b0, 32'h18,        8'hFF, 64'h0,                1'b0, T_ACK, 64'h00000000000000AA, 16'd10};
        vecs[12] = '{1'b0, 32'h800,       8'hFF, 64'h0,                1'b0, T_ERR, 64'h0,                16'd10};
        vecs[13] = '{1'b0, 32'h1F,        8'hFF, 64'h0,                1'b0, T_ACK, 64'h00000000000000AA, 16'd11};
        vecs[14] = '{1'b0, 32'h10,        8'hFF, 64'h0,                1'b1, T_RTY, 64'h0,                16'd11};
        vecs[15] = '{1'b1, 32'h10,        8'h00, 64'hFFFFFFFFFFFFFFFF, 1'b0, T_ACK, 64'h0,                16'd12};
        vecs[16] = '{1'b0, 32'h10,        8'hFF, 64'h0,                1'b0, T_ACK, 64'h11223344FFFFFFFF, 16'd13};
        vecs[17] = '{1'b1, 32'h1000_0010, 8'hFF, 64'h0,                1'b1, T_ERR, 64'h11223344FFFFFFFF, 16'd13};
        vecs[18] = '{1'b0, 32'h10,        8'hFF, 64'h0,                1'b0, T_ACK, 64'h11223344FFFFFFFF, 16'd14};

        rst0 = 1'b1; rst3 = 1'b1; rty_req0 = 1'b0; rty_req3 = 1'b0;
        if0.wb_cyc_i = 1'b0; if0.wb_stb_i = 1'b0; if0.wb_we_i = 1'b0;
        if0.wb_adr_i = '0; if0.wb_sel_i = '0; if0.wb_dat_i = '0;
        if3.wb_cyc_i = 1'b0; if3.wb_stb_i = 1'b0; if3.wb_we_i = 1'b0;
        if3.wb_adr_i = '0; if3.wb_sel_i = '0; if3.wb_dat_i = '0;
        repeat (3) @(negedge clk);
        rst0 = 1'b0; rst3 = 1'b0;
        @(negedge clk);
        check("reset term0", {if0.wb_ack_o, if0.wb_err_o, if0.wb_rty_o}, T_NONE);
        check("reset dat0",  if0.wb_dat_o, 64'h0);
        check("reset cnt0",  cnt0, 16'd0);
        check("reset term3", {if3.wb_ack_o, if3.wb_err_o, if3.wb_rty_o}, T_NONE);
        check("reset cnt3",  cnt3, 16'd0);

        // Directed vector table on the zero-wait slave.
        for (int i = 0; i < 19; i++) begin
            xfer0(vecs[i].we, vecs[i].adr, vecs[i].sel, vecs[i].dat, vecs[i].rty, term, rd, cnt, lat);
            check($sformatf("vec%0d term", i), term, vecs[i].exp_t);
            check($sformatf("vec%0d lat", i),  lat, 1);
            check($sformatf("vec%0d dat", i),  rd, vecs[i].exp_dat);
            check($sformatf("vec%0d cnt", i),  cnt, vecs[i].exp_cnt);
        end
        exp_dat = vecs[18].exp_dat;
        exp_cnt = vecs[18].exp_cnt;

        // Seed words 0..15 so the model knows every word random traffic can touch.
        for (int i = 0; i < 16; i++) begin
            dat = {$urandom, $urandom};
            xfer0(1'b1, 32'(i * 8), 8'hFF, dat, 1'b0, term, rd, cnt, lat);
            mdl[i] = dat;
            exp_cnt = exp_cnt + 16'd1;
            check($sformatf("seed%0d term", i), term, T_ACK);
        end

        for (int n = 0; n < 150; n++) begin
            we  = 1'($urandom_range(0, 1));
            rty = ($urandom_range(0, 7) == 0);
            oor = ($urandom_range(0, 7) == 0);
            sel = 8'($urandom);
            dat = {$urandom, $urandom};
            idx = $urandom_range(0, 15);
            adr = oor ? ($urandom | 32'h0000_0800) : 32'(idx * 8 + $urandom_range(0, 7));
            exp_t = oor ? T_ERR : (rty ? T_RTY : T_ACK);
            if (exp_t == T_ACK) begin
                exp_cnt = exp_cnt + 16'd1;
                if (we) begin
                    for (int b = 0; b < 8; b++) if (sel[b]) mdl[idx][8*b +: 8] = dat[8*b +: 8];
                end else begin
                    exp_dat = mdl[idx];
                end
            end else if (!we) begin
                exp_dat = '0;
            end
            xfer0(we, adr, sel, dat, rty, term, rd, cnt, lat);
            check($sformatf("rnd%0d term", n), term, exp_t);
            check($sformatf("rnd%0d lat", n),  lat, 1);
            check($sformatf("rnd%0d dat", n),  rd, exp_dat);
            check($sformatf("rnd%0d cnt", n),  cnt, exp_cnt);
        end

        // A read held across its ack is re-accepted in IDLE: acks every other cycle.
        @(negedge clk);
        if0.wb_cyc_i = 1'b1; if0.wb_stb_i = 1'b1; if0.wb_we_i = 1'b0;
        if0.wb_adr_i = 32'h0; if0.wb_sel_i = 8'hFF;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check($sformatf("b2b ack%0d", i), if0.wb_ack_o, 64'((i % 2) == 1));
        end
        if0.wb_cyc_i = 1'b0; if0.wb_stb_i = 1'b0;
        exp_cnt = exp_cnt + 16'd2;
        @(negedge clk);
        check("b2b idle term", {if0.wb_ack_o, if0.wb_err_o, if0.wb_rty_o}, T_NONE);
        check("b2b cnt",       cnt0, exp_cnt);
        check("b2b dat hold",  if0.wb_dat_o, mdl[0]);

        // Three-wait slave: latency, abort, late retry request, reset mid-transfer.
        xfer3(1'b1, 32'h8, 64'hA5A5A5A5_0000_0008, 0, 0, term, rd, cnt, lat);
        check("w3 wr8 term", term, T_ACK);
        check("w3 wr8 lat",  lat, 4);
        xfer3(1'b1, 32'h10, 64'h1122334455667788, 0, 0, term, rd, cnt, lat);
        check("w3 wr10 cnt", cnt, 16'd2);
        xfer3(1'b0, 32'h8, 64'h0, 0, 0, term, rd, cnt, lat);
        check("w3 rd8 term", term, T_ACK);
        check("w3 rd8 lat",  lat, 4);
        check("w3 rd8 dat",  rd, 64'hA5A5A5A5_0000_0008);
        check("w3 rd8 cnt",  cnt, 16'd3);
        xfer3(1'b0, 32'h8, 64'h0, 2, 0, term, rd, cnt, lat);
        check("w3 abort term", term, T_NONE);
        check("w3 abort cnt",  cnt3, 16'd3);
        xfer3(1'b0, 32'h10, 64'h0, 0, 0, term, rd, cnt, lat);
        check("w3 post-abort lat", lat, 4);
        check("w3 post-abort dat", rd, 64'h1122334455667788);
        xfer3(1'b0, 32'h8, 64'h0, 0, 1, term, rd, cnt, lat);
        check("w3 late rty term", term, T_ACK);
        check("w3 late rty cnt",  cnt, 16'd5);

        @(negedge clk);
        if3.wb_cyc_i = 1'b1; if3.wb_stb_i = 1'b1; if3.wb_we_i = 1'b1;
        if3.wb_adr_i = 32'h10; if3.wb_sel_i = 8'hFF; if3.wb_dat_i = 64'hFFFF_0000_FFFF_0000;
        repeat (2) @(negedge clk);
        rst3 = 1'b1;
        #1;
        check("w3 rst term", {if3.wb_ack_o, if3.wb_err_o, if3.wb_rty_o}, T_NONE);
        check("w3 rst dat",  if3.wb_dat_o, 64'h0);
        check("w3 rst cnt",  cnt3, 16'd0);
        @(negedge clk);
        rst3 = 1'b0; if3.wb_cyc_i = 1'b0; if3.wb_stb_i = 1'b0;
        xfer3(1'b0, 32'h10, 64'h0, 0, 0, term, rd, cnt, lat);
        check("w3 after rst term", term, T_ACK);
        check("w3 after rst lat",  lat, 4);
        check("w3 after rst dat",  rd, 64'h1122334455667788);
        check("w3 after rst cnt",  cnt, 16'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
